// File: rtl/mvm_sequencer_pkg.sv
// Shared definitions for the matrix-vector multiply sequencer.
// The default dimensions match the values in sys_defs.svh.
package mvm_sequencer_pkg;

  localparam int DEF_INPUT_WIDTH  = 16;
  localparam int DEF_INPUT_HEIGHT = 16;
  localparam int DEF_STREAM_LEN   = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    COMPUTE = 3'd2,
    WRITE   = 3'd3,
    FINISH  = 3'd4
  } mvm_seq_state_t;

  // Index width for a dimension of n entries. A one-entry dimension still
  // gets a one-bit index so that its ports never collapse to zero width.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_stream_counter.sv
// Counts the cycles of one stochastic stream and flags its last cycle.
module mvm_stream_counter
  import mvm_sequencer_pkg::*;
#(
  parameter int STREAM_LEN = DEF_STREAM_LEN,
  parameter int STREAM_LOG = idx_bits(STREAM_LEN)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [STREAM_LOG-1:0] LAST_COUNT = STREAM_LOG'(STREAM_LEN - 1);

  logic [STREAM_LOG-1:0] count_q;
  logic [STREAM_LOG-1:0] count_d;

  // Next count: clear has priority over enable.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no branch leaves it unassigned and infers a latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + STREAM_LOG'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LAST_COUNT);

endmodule

// File: rtl/mvm_sequencer.sv
// Control FSM for the bit-serial matrix-vector multiply datapath: walks
// the matrix row-major, fetches operands per element, enables the MAC array
// for one full stream per element and hands off each row result.
module mvm_sequencer
  import mvm_sequencer_pkg::*;
#(
  parameter int INPUT_WIDTH      = DEF_INPUT_WIDTH,
  parameter int INPUT_HEIGHT     = DEF_INPUT_HEIGHT,
  parameter int STREAM_LEN       = DEF_STREAM_LEN,
  parameter int INPUT_WIDTH_LOG  = idx_bits(INPUT_WIDTH),
  parameter int INPUT_HEIGHT_LOG = idx_bits(INPUT_HEIGHT),
  parameter int STREAM_LOG       = idx_bits(STREAM_LEN)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        operand_req,
  input  logic                        operand_ack,
  output logic [INPUT_WIDTH_LOG-1:0]  width_index,
  output logic [INPUT_HEIGHT_LOG-1:0] height_index,
  output logic                        mac_clear,
  output logic                        mac_enable,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic [INPUT_HEIGHT_LOG-1:0] row_index
);

  localparam logic [INPUT_WIDTH_LOG-1:0]  WIDTH_LAST  = INPUT_WIDTH_LOG'(INPUT_WIDTH - 1);
  localparam logic [INPUT_HEIGHT_LOG-1:0] HEIGHT_LAST = INPUT_HEIGHT_LOG'(INPUT_HEIGHT - 1);

  mvm_seq_state_t              state_q;
  mvm_seq_state_t              state_d;
  logic [INPUT_WIDTH_LOG-1:0]  width_idx_q;
  logic [INPUT_WIDTH_LOG-1:0]  width_idx_d;
  logic [INPUT_HEIGHT_LOG-1:0] height_idx_q;
  logic [INPUT_HEIGHT_LOG-1:0] height_idx_d;

  logic stream_clear;
  logic stream_enable;
  logic stream_last;

  // The counter sits at zero outside COMPUTE, so every element starts its
  // stream from zero, and wraps itself on the last stream cycle.
  assign stream_enable = (state_q == COMPUTE);
  assign stream_clear  = (state_q != COMPUTE) || stream_last;

  mvm_stream_counter #(
    .STREAM_LEN (STREAM_LEN),
    .STREAM_LOG (STREAM_LOG)
  ) u_stream_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (stream_clear),
    .enable (stream_enable),
    .last   (stream_last)
  );

  // State and index registers; reset aborts any pass in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      width_idx_q  <= '0;
      height_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      width_idx_q  <= width_idx_d;
      height_idx_q <= height_idx_d;
    end
  end

  // Next state and index stepping; indices are compared before they are
  // incremented, so they never leave their legal range.
  always_comb begin
    state_d      = state_q;
    width_idx_d  = width_idx_q;
    height_idx_d = height_idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FETCH;
          width_idx_d  = '0;
          height_idx_d = '0;
        end
      end
      FETCH: begin
        if (operand_ack) begin
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (stream_last) begin
          if (width_idx_q == WIDTH_LAST) begin
            state_d = WRITE;
          end else begin
            width_idx_d = width_idx_q + INPUT_WIDTH_LOG'(1);
            state_d     = FETCH;
          end
        end
      end
      WRITE: begin
        if (row_ready) begin
          if (height_idx_q == HEIGHT_LAST) begin
            state_d = FINISH;
          end else begin
            height_idx_d = height_idx_q + INPUT_HEIGHT_LOG'(1);
            width_idx_d  = '0;
            state_d      = FETCH;
          end
        end
      end
      FINISH: begin
        state_d      = IDLE;
        width_idx_d  = '0;
        height_idx_d = '0;
      end
      default: begin
        state_d      = IDLE;
        width_idx_d  = '0;
        height_idx_d = '0;
      end
    endcase
  end

  // Moore output decode from registered state and indices only.
  always_comb begin
    busy         = (state_q != IDLE);
    done         = 1'b0;
    operand_req  = 1'b0;
    mac_clear    = 1'b0;
    mac_enable   = 1'b0;
    row_valid    = 1'b0;
    row_index    = '0;
    width_index  = width_idx_q;
    height_index = height_idx_q;
    unique case (state_q)
      FETCH: begin
        operand_req = 1'b1;
        mac_clear   = (width_idx_q == '0);
      end
      COMPUTE: mac_enable = 1'b1;
      WRITE: begin
        row_valid = 1'b1;
        row_index = height_idx_q;
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mvm_sequencer.sv
// Self-checking bench for mvm_sequencer. A reference model derives, from
// the per-element ack delays and per-row ready delays, the cycle of every
// operand handshake, row handshake and done pulse; a monitor compares the
// DUT against those expectations as the events appear.
module tb_mvm_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int S  = 4;
  localparam int WL = 2;
  localparam int HL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (W=4, H=2, S=4)
  logic          reset, start, operand_ack, row_ready;
  logic          busy, done, operand_req, mac_clear, mac_enable, row_valid;
  logic [WL-1:0] width_index;
  logic [HL-1:0] height_index, row_index;

  // Corner DUT (W=1, H=1, S=1), ack and ready tied high
  logic       s_reset, s_start, s_ack, s_ready;
  logic       s_busy, s_done, s_operand_req, s_mac_clear, s_mac_enable, s_row_valid;
  logic [0:0] s_width_index, s_height_index, s_row_index;

  mvm_sequencer #(
    .INPUT_WIDTH  (W),
    .INPUT_HEIGHT (H),
    .STREAM_LEN   (S)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .operand_req  (operand_req),
    .operand_ack  (operand_ack),
    .width_index  (width_index),
    .height_index (height_index),
    .mac_clear    (mac_clear),
    .mac_enable   (mac_enable),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_index    (row_index)
  );

  mvm_sequencer #(
    .INPUT_WIDTH  (1),
    .INPUT_HEIGHT (1),
    .STREAM_LEN   (1)
  ) dut_small (
    .clock        (clk),
    .reset        (s_reset),
    .start        (s_start),
    .busy         (s_busy),
    .done         (s_done),
    .operand_req  (s_operand_req),
    .operand_ack  (s_ack),
    .width_index  (s_width_index),
    .height_index (s_height_index),
    .mac_clear    (s_mac_clear),
    .mac_enable   (s_mac_enable),
    .row_valid    (s_row_valid),
    .row_ready    (s_ready),
    .row_index    (s_row_index)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct { int h; int w; int cyc; } op_exp_t;
  typedef struct { int h; int cyc; }        row_exp_t;
  typedef struct { int cyc; int macs; }     done_exp_t;

  op_exp_t   op_q[$];
  row_exp_t  row_q[$];
  done_exp_t done_q[$];

  int op_delay  [H][W];
  int row_delay [H];
  bit noise_en;

  // Timeline of one pass: each element costs one FETCH cycle plus its ack
  // wait plus a full stream; each row costs one WRITE cycle plus its ready
  // wait; done follows the last row handoff by one cycle.
  task automatic model_push(input int start_cyc);
    int t;
    t = start_cyc;
    for (int hh = 0; hh < H; hh++) begin
      for (int ww = 0; ww < W; ww++) begin
        t += 1 + op_delay[hh][ww];
        op_q.push_back('{h: hh, w: ww, cyc: t});
        t += S;
      end
      t += 1 + row_delay[hh];
      row_q.push_back('{h: hh, cyc: t});
    end
    done_q.push_back('{cyc: t + 1, macs: W * H * S});
  endtask

  task automatic clear_delays();
    for (int hh = 0; hh < H; hh++) begin
      row_delay[hh] = 0;
      for (int ww = 0; ww < W; ww++) op_delay[hh][ww] = 0;
    end
  endtask

  // ---------------- monitor ----------------
  op_exp_t   m_op;
  row_exp_t  m_row;
  done_exp_t m_done;
  int        mac_count  = 0;
  logic      prev_stall = 1'b0;
  logic [HL-1:0] prev_row_idx = '0;

  always @(negedge clk) begin
    if (reset) begin
      mac_count  = 0;
      prev_stall = 1'b0;
    end else begin
      if (mac_enable) mac_count++;
      if (row_valid) check("mac_enable during write", mac_enable, 0);
      if (prev_stall) begin
        check("row_valid held in stall", row_valid, 1);
        check("row_index held in stall", row_index, prev_row_idx);
      end
      if (operand_req) begin
        if (op_q.size() == 0) begin
          check("unexpected operand_req", operand_req, 0);
        end else begin
          m_op = op_q[0];
          check("fetch width_index", width_index, m_op.w);
          check("fetch height_index", height_index, m_op.h);
          check("fetch mac_clear", mac_clear, (m_op.w == 0));
          if (operand_ack) begin
            check("operand handshake cycle", cyc, m_op.cyc);
            void'(op_q.pop_front());
          end
        end
      end
      if (row_valid) begin
        if (row_q.size() == 0) begin
          check("unexpected row_valid", row_valid, 0);
        end else begin
          m_row = row_q[0];
          check("row_index", row_index, m_row.h);
          if (row_ready) begin
            check("row handshake cycle", cyc, m_row.cyc);
            void'(row_q.pop_front());
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected done", done, 0);
        end else begin
          m_done = done_q.pop_front();
          check("done cycle", cyc, m_done.cyc);
          check("mac_enable cycles per pass", mac_count, m_done.macs);
          check("busy during finish", busy, 1);
          mac_count = 0;
        end
      end
      prev_stall   = row_valid && !row_ready;
      prev_row_idx = row_index;
    end
  end

  // ---------------- driver ----------------
  function automatic logic noise();
    return noise_en ? 1'($urandom_range(1)) : 1'b0;
  endfunction

  task automatic drive_pass();
    int budget;
    start = 1'b1;
    model_push(cyc);
    step();
    start = 1'b0;
    for (int hh = 0; hh < H; hh++) begin
      for (int ww = 0; ww < W; ww++) begin
        budget = 0;
        while (!operand_req && budget < 2000) begin
          operand_ack = noise();
          row_ready   = noise();
          start       = noise();
          step();
          budget++;
        end
        if (!operand_req) begin
          check("operand_req timeout", operand_req, 1);
          return;
        end
        repeat (op_delay[hh][ww]) begin
          operand_ack = 1'b0;
          row_ready   = noise();
          start       = noise();
          step();
        end
        operand_ack = 1'b1;
        step();
        operand_ack = 1'b0;
      end
      budget = 0;
      while (!row_valid && budget < 2000) begin
        operand_ack = noise();
        row_ready   = noise();
        start       = noise();
        step();
        budget++;
      end
      if (!row_valid) begin
        check("row_valid timeout", row_valid, 1);
        return;
      end
      repeat (row_delay[hh]) begin
        row_ready   = 1'b0;
        operand_ack = noise();
        start       = noise();
        step();
      end
      row_ready = 1'b1;
      step();
      row_ready = 1'b0;
    end
    // Now in the FINISH cycle: a start here must be ignored.
    start       = noise();
    operand_ack = 1'b0;
    step();
    start = 1'b0;
    check("busy low after finish", busy, 0);
    check("no fetch after finish", operand_req, 0);
    check("done queue drained", done_q.size(), 0);
    check("operand queue drained", op_q.size(), 0);
    step();
    check("still idle", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    int t0;
    reset       = 1'b1;
    start       = 1'b0;
    operand_ack = 1'b0;
    row_ready   = 1'b0;
    s_reset     = 1'b1;
    s_start     = 1'b0;
    s_ack       = 1'b1;
    s_ready     = 1'b1;
    noise_en    = 1'b0;
    clear_delays();

    start = 1'b1;  // start together with reset: reset wins
    repeat (3) step();
    start = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset operand_req", operand_req, 0);
    check("reset mac_clear", mac_clear, 0);
    check("reset mac_enable", mac_enable, 0);
    check("reset row_valid", row_valid, 0);
    check("reset width_index", width_index, 0);
    check("reset height_index", height_index, 0);
    check("reset row_index", row_index, 0);
    reset   = 1'b0;
    s_reset = 1'b0;
    step();
    check("idle after reset", busy, 0);

    // Ack and ready immediate: done 43 cycles after start.
    drive_pass();

    // Ack delayed 3 cycles on element (0,2).
    op_delay[0][2] = 3;
    drive_pass();

    // Ready held low for 5 cycles in the first WRITE.
    clear_delays();
    row_delay[0] = 5;
    drive_pass();

    // Random delays with noise on ignored inputs and start while busy.
    noise_en = 1'b1;
    for (int p = 0; p < 6; p++) begin
      for (int hh = 0; hh < H; hh++) begin
        row_delay[hh] = $urandom_range(0, 4);
        for (int ww = 0; ww < W; ww++) op_delay[hh][ww] = $urandom_range(0, 4);
      end
      drive_pass();
      repeat ($urandom_range(0, 3)) begin
        operand_ack = noise();
        row_ready   = noise();
        step();
      end
      operand_ack = 1'b0;
      row_ready   = 1'b0;
    end
    noise_en = 1'b0;
    clear_delays();

    // Reset during COMPUTE of element (1,1) aborts the pass.
    operand_ack = 1'b1;
    row_ready   = 1'b1;
    start       = 1'b1;
    model_push(cyc);
    step();
    start  = 1'b0;
    budget = 0;
    while (!(mac_enable && height_index == 1 && width_index == 1) && budget < 200) begin
      step();
      budget++;
    end
    check("reached compute (1,1)", mac_enable && height_index == 1 && width_index == 1, 1);
    reset = 1'b1;
    step();
    op_q.delete();
    row_q.delete();
    done_q.delete();
    reset = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort operand_req", operand_req, 0);
    check("abort mac_enable", mac_enable, 0);
    check("abort mac_clear", mac_clear, 0);
    check("abort row_valid", row_valid, 0);
    check("abort width_index", width_index, 0);
    check("abort height_index", height_index, 0);
    repeat (60) step();
    check("stays idle after abort", busy, 0);
    operand_ack = 1'b0;
    row_ready   = 1'b0;
    drive_pass();

    // Corner configuration W=1, H=1, S=1.
    s_start = 1'b1;
    t0      = cyc;
    step();
    s_start = 1'b0;
    check("small fetch cycle", cyc - t0, 1);
    check("small operand_req", s_operand_req, 1);
    check("small mac_clear", s_mac_clear, 1);
    check("small busy", s_busy, 1);
    step();
    check("small mac_enable", s_mac_enable, 1);
    check("small no req in compute", s_operand_req, 0);
    step();
    check("small row_valid", s_row_valid, 1);
    check("small row_index", s_row_index, 0);
    check("small no mac in write", s_mac_enable, 0);
    step();
    check("small done cycle", cyc - t0, 4);
    check("small done", s_done, 1);
    check("small busy in finish", s_busy, 1);
    step();
    check("small done one cycle", s_done, 0);
    check("small busy after finish", s_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mvm_sequencer.md
Name: mvm_sequencer

Overview:
- Top-level control FSM for the bit-serial matrix-vector multiply datapath.
- Walks the input matrix row-major and, per element, requests operands and then holds the MAC array enabled for one full stochastic stream.
- At the end of each row it hands the row result off through a valid/ready handshake.
- Owns the width/height indices, so the datapath and operand memories only decode state.

Parameters:
- INPUT_WIDTH, 16: columns per row (elements per dot product).
- INPUT_HEIGHT, 16: rows per matrix.
- STREAM_LEN, 256: compute cycles per element (bit-stream length).
- INPUT_WIDTH_LOG, $clog2(INPUT_WIDTH): width index bits.
- INPUT_HEIGHT_LOG, $clog2(INPUT_HEIGHT): height index bits.
- STREAM_LOG, $clog2(STREAM_LEN): stream counter bits.

Ports:
- clock  in  1  single system clock, all state on posedge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  begin one full matrix pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- operand_req  out  1  request operand fetch for the current (height_index, width_index).
- operand_ack  in  1  operands valid this cycle.
- width_index  out  INPUT_WIDTH_LOG  current column.
- height_index  out  INPUT_HEIGHT_LOG  current row.
- mac_clear  out  1  clear row accumulator.
- mac_enable  out  1  MAC array computes this cycle.
- row_valid  out  1  row result available.
- row_ready  in  1  consumer accepts the row result.
- row_index  out  INPUT_HEIGHT_LOG  row that row_valid refers to.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; width_index, height_index and stream counter all 0; every output 0. Reset mid-pass aborts immediately, with no done and no row_valid.
- Outputs are Moore-decoded from the registered state and counters. No combinational input-to-output path.
- States: IDLE, FETCH, COMPUTE, WRITE, FINISH.
- IDLE:
  - On start=1, go to FETCH with both indices at 0.
  - start in any other state is ignored.
- FETCH:
  - operand_req=1. mac_clear=1 when width_index==0.
  - On operand_ack=1, go to COMPUTE with stream_cnt=0.
  - Otherwise hold. Wait is unbounded.
- COMPUTE:
  - mac_enable=1 for exactly STREAM_LEN consecutive cycles. stream_cnt increments each cycle.
  - At stream_cnt==STREAM_LEN-1: if width_index==INPUT_WIDTH-1, go to WRITE with the index unchanged; else width_index+1 and go to FETCH.
- WRITE:
  - row_valid=1 and row_index=height_index, held stable until row_ready.
  - On row_ready=1: if height_index==INPUT_HEIGHT-1, go to FINISH; else height_index+1, width_index=0, go to FETCH.
- FINISH: done=1 for one cycle. Both indices clear to 0. Next state is IDLE. busy=1 during FINISH.
- Latency:
  - start sampled at edge t gives operand_req at cycle t+1.
  - With ack and ready always high, done is asserted H*(W*(STREAM_LEN+1)+1)+1 cycles after the start cycle.
- Wrap-around: indices never exceed INPUT_WIDTH-1 or INPUT_HEIGHT-1. Arithmetic is unsigned modulo-free, because the compare-before-increment rule guarantees this.
- Simultaneous events:
  - operand_ack outside FETCH and row_ready outside WRITE are ignored.
  - start together with reset: reset wins.
  - A start pulse in the same cycle as FINISH is ignored. A new start is accepted from IDLE onward.

Decomposition:
- Shared package: state enum typedef (mvm_seq_state_t) and default INPUT_WIDTH / INPUT_HEIGHT / STREAM_LEN constants, kept consistent with sys_defs.svh.
- One natural sub-module: mvm_stream_counter, a STREAM_LOG-bit counter with clear, enable and a last-cycle flag.
- Index stepping stays in the FSM.

Test Plan:
- W=4, H=2, S=4, ack and ready tied high; start pulse at cycle 0 -> done pulses at cycle 43 only; mac_enable high 32 cycles total; row_valid high at cycles 21 and 42 with row_index 0 then 1.
- Same config, operand_ack delayed 3 cycles on element (0,2) -> operand_req held 4 cycles; width_index stays 2 throughout the delay; done moves to cycle 46.
- row_ready low for 5 cycles in the first WRITE -> row_valid and row_index=0 stable all 6 cycles; no mac_enable during the stall; height_index then becomes 1 and width_index 0.
- Reset asserted during COMPUTE of (1,1) -> next cycle all outputs 0 and state IDLE; no done; a fresh start yields the full 43-cycle pass.
- start pulsed again while busy, and during FINISH -> ignored; exactly one done; busy low after FINISH.
- W=1, H=1, S=1 corner -> FETCH, COMPUTE, WRITE, FINISH at cycles 1-4 after start; mac_clear=1 in FETCH; done at cycle 4.
